floo_rsp_dispatch: RTL
======================

Name: floo_rsp_dispatch

Overview:
- Receive end of the FlooRsp link in a single-AXI network interface. It accepts response flits and decodes their AXI channel field. B flits go to the B output and R flits go to the R output, each through a registered per-channel FIFO.
- Flits carrying a request channel (AW/W/AR) on the response link are illegal. The block drops them and flags an error.
- It also tracks R burst state and counts delivered responses for debug and performance monitoring.
- Sits between the response-link router port and the NI's reorder/AXI response logic.

Parameters:
- PayloadWidth, 64, flit payload bits (max of B/R payload plus reserved bits).
- BWidth, 8, B payload bits; taken from payload_i[BWidth-1:0]; must be ≤ PayloadWidth.
- RWidth, 63, R payload bits; taken from payload_i[RWidth-1:0]; must be ≤ PayloadWidth.
- FifoDepth, 2, entries per channel FIFO; must be ≥ 1.
- CntWidth, 8, width of the saturating counters.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- valid_i  in  1  flit valid
- ready_o  out  1  flit ready
- axi_ch_i  in  3  channel encoding: AW=0, W=1, AR=2, B=3, R=4
- last_i  in  1  last beat of an R burst (ignored for B)
- payload_i  in  PayloadWidth  flit payload
- b_valid_o  out  1  B output valid
- b_ready_i  in  1  B output ready
- b_payload_o  out  BWidth  B payload
- r_valid_o  out  1  R output valid
- r_ready_i  in  1  R output ready
- r_payload_o  out  RWidth  R payload
- r_last_o  out  1  R last
- r_burst_active_o  out  1  R burst open (some beats accepted, last not yet accepted)
- err_o  out  1  sticky illegal-channel flag
- err_cnt_o  out  CntWidth  saturating count of dropped flits
- b_cnt_o  out  CntWidth  saturating count of B handshakes on the output side
- r_burst_cnt_o  out  CntWidth  saturating count of R handshakes with r_last_o=1

Behaviour:
- **Reset:** all FIFOs empty. All outputs are 0 (b_valid_o, r_valid_o, r_last_o, r_burst_active_o, err_o, all counters); payload outputs are 0.
- **Input handshake:** a flit transfers when valid_i && ready_o. ready_o may depend combinationally on axi_ch_i; it never depends on b_ready_i or r_ready_i.
  - axi_ch_i=B: ready_o = !b_full.
  - axi_ch_i=R: ready_o = !r_full.
  - Any other value (0, 1, 2, 5–7): ready_o = 1, and the flit is dropped.
- **Full FIFO:** a pop in the same cycle does not free a slot for the input. A full FIFO accepts no push that cycle, even if it is draining.
- **Latency:** a flit accepted in cycle n is visible at the output in cycle n+1 at the earliest. There is no combinational path from input to output.
- **Output channels:** b_valid_o = !b_empty and r_valid_o = !r_empty. Output data comes from the FIFO head and stays stable while valid && !ready.
  - B and R are independent. A stalled B output does not block R flits unless the head flit on the link is a B, which blocks in-order.
- **FIFOs:** circular, depth FifoDepth; the read pointer advances on pop and the write pointer on push. Pointers wrap modulo FifoDepth, and full/empty are tracked with a count register. Simultaneous push and pop on a non-full, non-empty FIFO leaves the count unchanged.
- **R burst state (FSM IDLE/BURST), driven by input-side R pushes:**
  - IDLE → BURST on an R push with last_i=0.
  - BURST → IDLE on an R push with last_i=1.
  - IDLE stays IDLE on an R push with last_i=1 (single-beat burst).
  - r_burst_active_o = (state==BURST).
- **Error path:** an illegal flit sets err_o, which stays 1 until reset. err_cnt_o increments by 1 per illegal flit and saturates at 2^CntWidth−1.
- **Counters:** b_cnt_o increments per b_valid_o&&b_ready_i; r_burst_cnt_o increments per r_valid_o&&r_ready_i&&r_last_o. Both saturate at the maximum and never wrap.
- **Reset mid-operation:** FIFO contents are discarded, the FSM returns to IDLE, and all counters and flags clear in the cycle after rst_i is sampled high. While rst_i=1, ready_o=0.

Test Plan:
1. **Basic dispatch:** after reset, push B (payload 0xA5), then R (payload 0x1234, last=1) in consecutive cycles with both readies=1.
   - b_valid_o is high with 0xA5 one cycle after its push.
   - r_valid_o is high with 0x1234 and r_last_o=1 the cycle after that.
   - Final state: b_cnt_o=1, r_burst_cnt_o=1.
2. **Backpressure / full:** hold r_ready_i=0 and push 3 R beats with FifoDepth=2.
   - Third beat: ready_o=0. Release r_ready_i for one cycle; ready_o stays 0 that cycle and rises the next.
   - Beats emerge in order with no loss or duplication.
3. **Head-of-line blocking:** b_ready_i=0, B FIFO full, head input flit is B, R FIFO empty.
   - ready_o=0 and no R activity. Setting axi_ch_i=R raises ready_o=1.
4. **Illegal channel:** push flits with axi_ch_i=0, 2, 6.
   - ready_o=1 for each; no output valids.
   - err_o=1 and err_cnt_o=3. With CntWidth=2, 5 illegal flits give err_cnt_o=3 (saturated).
5. **Burst tracking:** push R beats with last=0,0,1.
   - r_burst_active_o is 1 after the first push and 0 after the third. r_burst_cnt_o=1 once all three beats drain.
6. **Reset mid-operation:** assert rst_i with 2 B entries queued and the FSM in BURST.
   - Next cycle: b_valid_o=0, r_burst_active_o=0, err_o=0, and all counters 0.

Source files
------------

// File: rtl/floo_rsp_dispatch_if.sv
// Response-link dispatch interface.
// Groups the incoming FlooRsp flit handshake and the B and R output handshakes.
//   master : the link router and NI response logic (drives flits, consumes B/R)
//   slave  : floo_rsp_dispatch (accepts flits, produces B/R)
interface floo_rsp_dispatch_if #(
  parameter int unsigned PayloadWidth = 64,
  parameter int unsigned BWidth       = 8,
  parameter int unsigned RWidth       = 63
);
  // Incoming flit
  logic                    valid;
  logic                    ready;
  logic [2:0]              axi_ch;
  logic                    last;
  logic [PayloadWidth-1:0] payload;
  // B output
  logic                    b_valid;
  logic                    b_ready;
  logic [BWidth-1:0]       b_payload;
  // R output
  logic                    r_valid;
  logic                    r_ready;
  logic [RWidth-1:0]       r_payload;
  logic                    r_last;

  modport master (
    output valid, axi_ch, last, payload, b_ready, r_ready,
    input  ready, b_valid, b_payload, r_valid, r_payload, r_last
  );

  modport slave (
    input  valid, axi_ch, last, payload, b_ready, r_ready,
    output ready, b_valid, b_payload, r_valid, r_payload, r_last
  );
endinterface

// File: rtl/floo_rsp_dispatch.sv
// FlooRsp receive-side dispatcher.
// Decodes the AXI channel of each response flit and queues B and R flits in
// independent registered FIFOs. Request-channel flits are dropped and flagged.
// Ports:
//   clk_i, rst_i      clock, synchronous active-high reset
//   bus (slave)       flit input plus B and R output handshakes
//   r_burst_active_o  an R burst has started on the input but its last beat has not
//   err_o             sticky illegal-channel flag
//   err_cnt_o         saturating count of dropped flits
//   b_cnt_o           saturating count of B output handshakes
//   r_burst_cnt_o     saturating count of R output handshakes carrying last
//
// R burst FSM:
//   state | meaning
//   IDLE  | no R burst open on the input side
//   BURST | R beats accepted, last beat not yet accepted
module floo_rsp_dispatch #(
  parameter int unsigned PayloadWidth = 64,
  parameter int unsigned BWidth       = 8,
  parameter int unsigned RWidth       = 63,
  parameter int unsigned FifoDepth    = 2,
  parameter int unsigned CntWidth     = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  floo_rsp_dispatch_if.slave    bus,
  output logic                  r_burst_active_o,
  output logic                  err_o,
  output logic [CntWidth-1:0]   err_cnt_o,
  output logic [CntWidth-1:0]   b_cnt_o,
  output logic [CntWidth-1:0]   r_burst_cnt_o
);
  localparam int unsigned PtrW = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
  localparam int unsigned OccW = $clog2(FifoDepth + 1);
  localparam logic [PtrW-1:0]     PtrLast = PtrW'(FifoDepth - 1);
  localparam logic [OccW-1:0]     OccFull = OccW'(FifoDepth);
  localparam logic [CntWidth-1:0] CntMax  = '1;
  localparam logic [2:0]          ChB     = 3'd3;
  localparam logic [2:0]          ChR     = 3'd4;

  typedef enum logic {IDLE, BURST} burst_state_e;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrLast) ? '0 : p + 1'b1;
  endfunction

  logic [BWidth-1:0] b_mem_q [FifoDepth];
  logic [BWidth-1:0] b_mem_d [FifoDepth];
  logic [RWidth:0]   r_mem_q [FifoDepth];  // {last, payload}
  logic [RWidth:0]   r_mem_d [FifoDepth];
  logic [PtrW-1:0]   b_wptr_q, b_wptr_d, b_rptr_q, b_rptr_d;
  logic [PtrW-1:0]   r_wptr_q, r_wptr_d, r_rptr_q, r_rptr_d;
  logic [OccW-1:0]   b_occ_q, b_occ_d, r_occ_q, r_occ_d;
  logic              err_q, err_d;
  logic [CntWidth-1:0] err_cnt_q, err_cnt_d, b_cnt_q, b_cnt_d, r_burst_cnt_q, r_burst_cnt_d;
  burst_state_e      state_q;
  logic              r_burst_active_q;

  logic b_full, b_empty, r_full, r_empty, is_b, is_r, ready;
  logic b_push, r_push, ill_push, b_pop, r_pop, r_head_last;

  always_comb begin
    b_full  = (b_occ_q == OccFull);
    b_empty = (b_occ_q == '0);
    r_full  = (r_occ_q == OccFull);
    r_empty = (r_occ_q == '0);
    is_b    = (bus.axi_ch == ChB);
    is_r    = (bus.axi_ch == ChR);
    // Fullness comes from the registered count only, so a same-cycle pop
    // never opens a slot for the input.
    ready = 1'b0;
    if (!rst_i) begin
      if (is_b)      ready = !b_full;
      else if (is_r) ready = !r_full;
      else           ready = 1'b1;
    end
    b_push   = bus.valid && ready && is_b;
    r_push   = bus.valid && ready && is_r;
    ill_push = bus.valid && ready && !is_b && !is_r;
    b_pop    = !b_empty && bus.b_ready;
    r_pop    = !r_empty && bus.r_ready;
    r_head_last = r_mem_q[r_rptr_q][RWidth];

    b_mem_d = b_mem_q;
    r_mem_d = r_mem_q;
    if (b_push) b_mem_d[b_wptr_q] = bus.payload[BWidth-1:0];
    if (r_push) r_mem_d[r_wptr_q] = {bus.last, bus.payload[RWidth-1:0]};

    b_wptr_d = b_push ? ptr_inc(b_wptr_q) : b_wptr_q;
    b_rptr_d = b_pop  ? ptr_inc(b_rptr_q) : b_rptr_q;
    r_wptr_d = r_push ? ptr_inc(r_wptr_q) : r_wptr_q;
    r_rptr_d = r_pop  ? ptr_inc(r_rptr_q) : r_rptr_q;

    b_occ_d = b_occ_q;
    if (b_push && !b_pop)      b_occ_d = b_occ_q + 1'b1;
    else if (!b_push && b_pop) b_occ_d = b_occ_q - 1'b1;
    r_occ_d = r_occ_q;
    if (r_push && !r_pop)      r_occ_d = r_occ_q + 1'b1;
    else if (!r_push && r_pop) r_occ_d = r_occ_q - 1'b1;

    err_d         = err_q || ill_push;
    err_cnt_d     = (ill_push && err_cnt_q != CntMax) ? err_cnt_q + 1'b1 : err_cnt_q;
    b_cnt_d       = (b_pop && b_cnt_q != CntMax) ? b_cnt_q + 1'b1 : b_cnt_q;
    r_burst_cnt_d = (r_pop && r_head_last && r_burst_cnt_q != CntMax) ?
                    r_burst_cnt_q + 1'b1 : r_burst_cnt_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      b_mem_q       <= '{default: '0};
      r_mem_q       <= '{default: '0};
      b_wptr_q      <= '0;
      b_rptr_q      <= '0;
      r_wptr_q      <= '0;
      r_rptr_q      <= '0;
      b_occ_q       <= '0;
      r_occ_q       <= '0;
      err_q         <= 1'b0;
      err_cnt_q     <= '0;
      b_cnt_q       <= '0;
      r_burst_cnt_q <= '0;
    end else begin
      b_mem_q       <= b_mem_d;
      r_mem_q       <= r_mem_d;
      b_wptr_q      <= b_wptr_d;
      b_rptr_q      <= b_rptr_d;
      r_wptr_q      <= r_wptr_d;
      r_rptr_q      <= r_rptr_d;
      b_occ_q       <= b_occ_d;
      r_occ_q       <= r_occ_d;
      err_q         <= err_d;
      err_cnt_q     <= err_cnt_d;
      b_cnt_q       <= b_cnt_d;
      r_burst_cnt_q <= r_burst_cnt_d;
    end
  end

  // Burst tracking follows input-side R pushes, not output delivery.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q          <= IDLE;
      r_burst_active_q <= 1'b0;
    end else if (r_push) begin
      if (bus.last) begin
        state_q          <= IDLE;
        r_burst_active_q <= 1'b0;
      end else begin
        state_q          <= BURST;
        r_burst_active_q <= 1'b1;
      end
    end
  end

  assign bus.ready        = ready;
  assign bus.b_valid      = !b_empty;
  assign bus.b_payload    = b_mem_q[b_rptr_q];
  assign bus.r_valid      = !r_empty;
  assign bus.r_payload    = r_mem_q[r_rptr_q][RWidth-1:0];
  assign bus.r_last       = !r_empty && r_head_last;
  assign r_burst_active_o = r_burst_active_q;
  assign err_o            = err_q;
  assign err_cnt_o        = err_cnt_q;
  assign b_cnt_o          = b_cnt_q;
  assign r_burst_cnt_o    = r_burst_cnt_q;
endmodule
